dcache_wb: RTL and testbench



---
 rtl/dcache_wb_if.sv | 30 +++
 rtl/dcache_wb.sv | 196 +++++++++++++++++++
 tb/tb_dcache_wb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_if.sv
// rtl/dcache_wb_if.sv - CPU port and backing-memory beat bus of the write-back data cache
interface dcache_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              rd_en;
  logic              stall;
  logic              flush;
  logic              flush_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  addr, wr_data, wr_en, rd_en, flush, mem_rdata, mem_ack,
    output rd_data, stall, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, wr_data, wr_en, rd_en, flush, mem_rdata, mem_ack,
    input  rd_data, stall, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache with miss stall and flush
module dcache_wb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 128,
  parameter int LINE_WORDS = 4
) (
  input logic       clk,
  input logic       rst_n,
  dcache_wb_if.slave bus
);
  localparam int OFF_B  = $clog2(DATA_W / 8);
  localparam int WSEL_B = $clog2(LINE_WORDS);
  localparam int WSEL_W = (WSEL_B > 0) ? WSEL_B : 1;
  localparam int IDX_B  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF_B - WSEL_B - IDX_B;
  localparam int AW     = IDX_B + WSEL_W;

  typedef enum logic [2:0] {IDLE, WB, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*LINE_WORDS];
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;

  state_t             state;
  logic [IDX_B-1:0]   line_idx;
  logic [WSEL_W-1:0]  beat;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               flush_done_q;

  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_B-1:0]   cpu_idx;
  logic [WSEL_W-1:0]  cpu_word;
  logic               req;
  logic               hit;
  logic               last;
  logic               ack;
  logic               arr_we;
  logic [AW-1:0]      arr_waddr;
  logic [DATA_W-1:0]  arr_wdata;
  logic               tag_we;

  function automatic logic [AW-1:0] aidx(input logic [IDX_B-1:0] i, input logic [WSEL_W-1:0] w);
    return (AW'(i) << WSEL_B) | AW'(w);
  endfunction

  function automatic logic [ADDR_W-1:0] baddr(input logic [TAG_W-1:0] t, input logic [IDX_B-1:0] i,
                                              input logic [WSEL_W-1:0] w);
    return (ADDR_W'(t) << (OFF_B + WSEL_B + IDX_B)) | (ADDR_W'(i) << (OFF_B + WSEL_B)) |
           (ADDR_W'(w) << OFF_B);
  endfunction

  assign cpu_tag  = TAG_W'(bus.addr >> (OFF_B + WSEL_B + IDX_B));
  assign cpu_idx  = IDX_B'(bus.addr >> (OFF_B + WSEL_B));
  assign cpu_word = WSEL_W'(bus.addr >> OFF_B) & WSEL_W'(LINE_WORDS - 1);
  assign req      = bus.rd_en | bus.wr_en;
  assign hit      = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign last     = (beat == WSEL_W'(LINE_WORDS - 1));
  assign ack      = bus.mem_ack & mem_req_q;

  // Array write port shared between store hits and refill beats
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = aidx(cpu_idx, cpu_word);
    arr_wdata = bus.wr_data;
    if (rst_n) begin
      if (state == IDLE && !bus.flush && bus.wr_en && hit) begin
        arr_we = 1'b1;
      end else if (state == REFILL && ack) begin
        arr_we    = 1'b1;
        arr_waddr = aidx(line_idx, beat);
        arr_wdata = bus.mem_rdata;
      end
    end
  end

  assign tag_we = rst_n && (state == REFILL) && ack && last;

  always_ff @(posedge clk) begin
    if (arr_we) data_mem[arr_waddr] <= arr_wdata;
    if (tag_we) tag_mem[line_idx] <= cpu_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      line_idx     <= '0;
      beat         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flush) begin
            state    <= FLUSH_SCAN;
            line_idx <= '0;
          end else if (req && hit) begin
            if (bus.wr_en) dirty[cpu_idx] <= 1'b1;
          end else if (req) begin
            line_idx       <= cpu_idx;
            beat           <= '0;
            mem_req_q      <= 1'b1;
            valid[cpu_idx] <= 1'b0;
            if (valid[cpu_idx] && dirty[cpu_idx]) begin
              state       <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= baddr(tag_mem[cpu_idx], cpu_idx, '0);
              mem_wdata_q <= data_mem[aidx(cpu_idx, '0)];
            end else begin
              state      <= REFILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= baddr(cpu_tag, cpu_idx, '0);
            end
          end
        end
        WB, FLUSH_WB: begin
          if (ack) begin
            if (last) begin
              dirty[line_idx] <= 1'b0;
              beat            <= '0;
              if (state == WB) begin
                state      <= REFILL;
                mem_we_q   <= 1'b0;
                mem_addr_q <= baddr(cpu_tag, line_idx, '0);
              end else begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
                line_idx  <= line_idx + 1'b1;
                if (line_idx == IDX_B'(LINES - 1)) begin
                  state        <= IDLE;
                  flush_done_q <= 1'b1;
                end else begin
                  state <= FLUSH_SCAN;
                end
              end
            end else begin
              beat        <= beat + 1'b1;
              mem_addr_q  <= baddr(tag_mem[line_idx], line_idx, beat + 1'b1);
              mem_wdata_q <= data_mem[aidx(line_idx, beat + 1'b1)];
            end
          end
        end
        REFILL: begin
          if (ack) begin
            if (last) begin
              valid[line_idx] <= 1'b1;
              dirty[line_idx] <= 1'b0;
              mem_req_q       <= 1'b0;
              beat            <= '0;
              state           <= IDLE;
            end else begin
              beat       <= beat + 1'b1;
              mem_addr_q <= baddr(cpu_tag, line_idx, beat + 1'b1);
            end
          end
        end
        FLUSH_SCAN: begin
          if (valid[line_idx] && dirty[line_idx]) begin
            state       <= FLUSH_WB;
            beat        <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= baddr(tag_mem[line_idx], line_idx, '0);
            mem_wdata_q <= data_mem[aidx(line_idx, '0)];
          end else begin
            line_idx <= line_idx + 1'b1;
            if (line_idx == IDX_B'(LINES - 1)) begin
              state        <= IDLE;
              flush_done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush request wins over a same-cycle CPU access, which then waits
  assign bus.stall      = rst_n && ((state != IDLE) || (req && (bus.flush || !hit)));
  assign bus.rd_data    = rst_n ? data_mem[aidx(cpu_idx, cpu_word)] : '0;
  assign bus.flush_done = flush_done_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - scoreboard bench for dcache_wb: beat and load queues checked by a monitor
module tb_dcache_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_wb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dcache_wb #(.ADDR_W(32), .DATA_W(32), .LINES(128), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_loads[$];
  beat_t       mon_beat;
  logic [31:0] mon_load;
  int checks = 0;
  int errors = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int resp_cnt = 0;
  bit hold_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  task automatic push_rd_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_beats.push_back({1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_beats.push_back({1'b1, a, d});
  endtask

  // Backing memory: acks each beat after two idle cycles unless held off
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        resp_cnt    = 0;
      end else if (!bus.mem_req) begin
        resp_cnt = 0;
      end else if (!hold_ack) begin
        if (resp_cnt == 2) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_val(bus.mem_addr);
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req && bus.mem_ack) begin
        beat_cnt++;
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0h we %0b expected no beat", bus.mem_addr, bus.mem_we);
        end else begin
          mon_beat = exp_beats.pop_front();
          chk("beat_we", bus.mem_we, mon_beat.we);
          chk("beat_addr", bus.mem_addr, mon_beat.addr);
          if (mon_beat.we) chk("beat_wdata", bus.mem_wdata, mon_beat.data);
        end
      end
      if (bus.rd_en && !bus.wr_en && !bus.stall) begin
        if (exp_loads.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got %0h expected no load", bus.rd_data);
        end else begin
          mon_load = exp_loads.pop_front();
          chk("load_data", bus.rd_data, mon_load);
        end
      end
      if (bus.flush_done) done_cnt++;
    end
  end

  task automatic cpu_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int waited);
    bit ok;
    bus.addr    = a;
    bus.wr_data = d;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    waited      = 0;
    do begin
      @(negedge clk);
      ok = rst_n && !bus.stall;
      if (!ok) waited++;
    end while (!ok && waited <= 400);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: got stall still high at addr %0h expected release", a);
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, output int waited);
    exp_loads.push_back(exp);
    cpu_op(1'b0, 1'b1, a, 32'h0, waited);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int waited);
    cpu_op(1'b1, 1'b0, a, d, waited);
  endtask

  initial begin
    int w, w2, bc0, dc0, n;
    bus.addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.stall, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    push_rd_line(32'h40);
    load(32'h40, 32'h1000_0040, w);
    chk("cold_stall_cycles", w, 16);

    load(32'h48, 32'h1000_0048, w);
    chk("hit_load_stall", w, 0);
    store(32'h4C, 32'h1234_5678, w);
    chk("hit_store_stall", w, 0);
    load(32'h4C, 32'h1234_5678, w);
    chk("hit_reload_stall", w, 0);

    store(32'h44, 32'hDEAD_BEEF, w);
    chk("store_hit_stall", w, 0);
    push_wr(32'h40, 32'h1000_0040);
    push_wr(32'h44, 32'hDEAD_BEEF);
    push_wr(32'h48, 32'h1000_0048);
    push_wr(32'h4C, 32'h1234_5678);
    push_rd_line(32'h840);
    load(32'h840, 32'h1000_0840, w);

    store(32'h840, 32'hCAFE_F00D, w);
    chk("store_840_stall", w, 0);
    push_wr(32'h840, 32'hCAFE_F00D);
    push_wr(32'h844, 32'h1000_0844);
    push_wr(32'h848, 32'h1000_0848);
    push_wr(32'h84C, 32'h1000_084C);
    push_rd_line(32'h40);
    bc0 = beat_cnt;
    fork
      load(32'h40, 32'h1000_0040, w);
      begin
        n = 0;
        while (beat_cnt < bc0 + 1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #2;
        hold_ack = 1'b1;
        repeat (10) begin
          @(negedge clk);
          chk("hold_addr", bus.mem_addr, 32'h844);
          chk("hold_wdata", bus.mem_wdata, 32'h1000_0844);
          chk("hold_we", bus.mem_we, 1);
          chk("hold_req", bus.mem_req, 1);
        end
        chk("hold_beats", beat_cnt, bc0 + 1);
        hold_ack = 1'b0;
      end
    join

    push_rd_line(32'h0);
    store(32'h0, 32'hA0A0_0000, w);
    push_rd_line(32'h50);
    store(32'h54, 32'hA5A5_0005, w2);
    chk("miss_store_stalls", (w > 0) && (w2 > 0), 1);
    push_rd_line(32'h7F0);
    store(32'h7FC, 32'hA7F0_007F, w);
    push_wr(32'h0, 32'hA0A0_0000);   push_wr(32'h4, 32'h1000_0004);
    push_wr(32'h8, 32'h1000_0008);   push_wr(32'hC, 32'h1000_000C);
    push_wr(32'h50, 32'h1000_0050);  push_wr(32'h54, 32'hA5A5_0005);
    push_wr(32'h58, 32'h1000_0058);  push_wr(32'h5C, 32'h1000_005C);
    push_wr(32'h7F0, 32'h1000_07F0); push_wr(32'h7F4, 32'h1000_07F4);
    push_wr(32'h7F8, 32'h1000_07F8); push_wr(32'h7FC, 32'hA7F0_007F);
    dc0 = done_cnt;
    bus.flush = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.flush_done && n < 2000);
    bus.flush = 1'b0;
    chk("flush_done_seen", bus.flush_done, 1);
    repeat (5) @(negedge clk);
    chk("flush_done_pulses", done_cnt - dc0, 1);
    chk("flush_beats_left", exp_beats.size(), 0);
    @(posedge clk);
    #1;
    load(32'h58, 32'h1000_0058, w);
    chk("flush_reload_hit", w, 0);

    exp_beats.push_back({1'b0, 32'h100, 32'h0});
    exp_beats.push_back({1'b0, 32'h104, 32'h0});
    push_rd_line(32'h100);
    bc0 = beat_cnt;
    fork
      load(32'h100, 32'h1000_0100, w);
      begin
        n = 0;
        while (beat_cnt < bc0 + 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", bus.mem_req, 0);
        chk("abort_stall", bus.stall, 0);
        chk("abort_rd_data", bus.rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join

    repeat (3) @(negedge clk);
    chk("beats_left", exp_beats.size(), 0);
    chk("loads_left", exp_loads.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
